// File: rtl/sumador_operand_loader_if.sv
// Bundle between the operand loader and its surroundings: board switches and
// button, adder feedback, and the registered operands/result going out.
interface sumador_operand_loader_if #(
    parameter int WIDTH = 3
);
    logic [WIDTH-1:0] iSw;
    logic             iSwCin;
    logic             iBtn;
    logic [WIDTH-1:0] iS;
    logic             iCout;
    logic [WIDTH-1:0] oA;
    logic [WIDTH-1:0] oB;
    logic             oCin;
    logic [WIDTH:0]   oResult;
    logic             oValid;
    logic [1:0]       oState;

    // Board/adder side: drives the raw inputs, observes the loader outputs.
    modport master (
        output iSw, iSwCin, iBtn, iS, iCout,
        input  oA, oB, oCin, oResult, oValid, oState
    );

    // Loader side.
    modport slave (
        input  iSw, iSwCin, iBtn, iS, iCout,
        output oA, oB, oCin, oResult, oValid, oState
    );
endinterface

// File: rtl/sumador_operand_loader.sv
// Operand loader for the 3-bit ripple adder: a debounced button steps through
// load A, load B/Cin, settle-and-capture, then show/clear.
module sumador_operand_loader #(
    parameter int WIDTH   = 3,
    parameter int DEB_CNT = 4
) (
    input  logic                     iClk,
    input  logic                     iRst_n,
    sumador_operand_loader_if.slave  bus
);

    localparam int CW = (DEB_CNT > 1) ? $clog2(DEB_CNT) : 1;
    localparam logic [CW-1:0] CNT_MAX = CW'(DEB_CNT - 1);

    typedef enum logic [1:0] {
        LOAD_A = 2'b00,
        LOAD_B = 2'b01,
        SETTLE = 2'b10,
        SHOW   = 2'b11
    } state_t;

    logic [1:0]       sync_q,   sync_d;
    logic [CW-1:0]    deb_cnt_q, deb_cnt_d;
    logic             stable_q, stable_d;
    logic             stable_prev_q;
    logic             press_s;

    state_t           state_q,  state_d;
    logic [WIDTH-1:0] a_q,      a_d;
    logic [WIDTH-1:0] b_q,      b_d;
    logic             cin_q,    cin_d;
    logic [WIDTH:0]   result_q, result_d;
    logic             valid_q,  valid_d;

    // Two-flop synchroniser shift for the raw button.
    always_comb begin
        sync_d = {sync_q[0], bus.iBtn};
    end

    // Debounce: a new synced level must persist DEB_CNT cycles before it is accepted.
    always_comb begin
        deb_cnt_d = deb_cnt_q;
        stable_d  = stable_q;
        if (sync_q[1] == stable_q) begin
            deb_cnt_d = {CW{1'b0}};
        end else if (deb_cnt_q == CNT_MAX) begin
            stable_d  = sync_q[1];
            deb_cnt_d = {CW{1'b0}};
        end else begin
            deb_cnt_d = deb_cnt_q + CW'(1);
        end
    end

    assign press_s = stable_q & ~stable_prev_q;

    // Button path registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            sync_q        <= 2'b00;
            deb_cnt_q     <= {CW{1'b0}};
            stable_q      <= 1'b0;
            stable_prev_q <= 1'b0;
        end else begin
            sync_q        <= sync_d;
            deb_cnt_q     <= deb_cnt_d;
            stable_q      <= stable_d;
            stable_prev_q <= stable_q;
        end
    end

    // Sequencer next-state and registered-output updates.
    always_comb begin
        state_d  = state_q;
        a_d      = a_q;
        b_d      = b_q;
        cin_d    = cin_q;
        result_d = result_q;
        valid_d  = 1'b0;
        case (state_q)
            LOAD_A: begin
                if (press_s) begin
                    a_d     = bus.iSw;
                    state_d = LOAD_B;
                end else begin
                    state_d = LOAD_A;
                end
            end
            LOAD_B: begin
                if (press_s) begin
                    b_d     = bus.iSw;
                    cin_d   = bus.iSwCin;
                    state_d = SETTLE;
                end else begin
                    state_d = LOAD_B;
                end
            end
            SETTLE: begin
                // Operands have been on the adder inputs for a whole cycle by now.
                result_d = {bus.iCout, bus.iS};
                valid_d  = 1'b1;
                state_d  = SHOW;
            end
            SHOW: begin
                if (press_s) begin
                    a_d      = {WIDTH{1'b0}};
                    b_d      = {WIDTH{1'b0}};
                    cin_d    = 1'b0;
                    result_d = {(WIDTH+1){1'b0}};
                    state_d  = LOAD_A;
                end else begin
                    state_d = SHOW;
                end
            end
            default: begin
                a_d      = {WIDTH{1'b0}};
                b_d      = {WIDTH{1'b0}};
                cin_d    = 1'b0;
                result_d = {(WIDTH+1){1'b0}};
                state_d  = LOAD_A;
            end
        endcase
    end

    // Sequencer state and output registers.
    always_ff @(posedge iClk or negedge iRst_n) begin
        if (!iRst_n) begin
            state_q  <= LOAD_A;
            a_q      <= {WIDTH{1'b0}};
            b_q      <= {WIDTH{1'b0}};
            cin_q    <= 1'b0;
            result_q <= {(WIDTH+1){1'b0}};
            valid_q  <= 1'b0;
        end else begin
            state_q  <= state_d;
            a_q      <= a_d;
            b_q      <= b_d;
            cin_q    <= cin_d;
            result_q <= result_d;
            valid_q  <= valid_d;
        end
    end

    assign bus.oA      = a_q;
    assign bus.oB      = b_q;
    assign bus.oCin    = cin_q;
    assign bus.oResult = result_q;
    assign bus.oValid  = valid_q;
    assign bus.oState  = state_q;

endmodule

// File: tb/tb_sumador_operand_loader.sv
// Directed bench for the operand loader with a behavioural 3-bit adder attached.
module tb_sumador_operand_loader;

    localparam int WIDTH   = 3;
    localparam int DEB_CNT = 4;

    logic iClk;
    logic iRst_n;

    sumador_operand_loader_if #(.WIDTH(WIDTH)) bus ();

    sumador_operand_loader #(.WIDTH(WIDTH), .DEB_CNT(DEB_CNT)) dut (
        .iClk   (iClk),
        .iRst_n (iRst_n),
        .bus    (bus)
    );

    logic [WIDTH:0] sum_s;
    assign sum_s     = {1'b0, bus.oA} + {1'b0, bus.oB} + {3'b000, bus.oCin};
    assign bus.iS    = sum_s[WIDTH-1:0];
    assign bus.iCout = sum_s[WIDTH];

    initial iClk = 1'b0;
    always #5 iClk = ~iClk;

    int total = 0;
    int bad   = 0;
    int valid_cnt = 0;
    int valid_wrong_state = 0;

    always @(negedge iClk) begin
        if (bus.oValid) begin
            valid_cnt = valid_cnt + 1;
            if (bus.oState != 2'b11) valid_wrong_state = valid_wrong_state + 1;
        end
    end

    typedef struct {
        logic [2:0] a;
        logic [2:0] b;
        logic       cin;
        logic [3:0] res;
    } vec_t;

    vec_t vecs [6];

    task automatic check(input string name, input int act, input int exp);
        total = total + 1;
        if (act != exp) begin
            bad = bad + 1;
            $display("FAIL %s: got=%0d expected=%0d", name, act, exp);
        end
    endtask

    task automatic cycles(input int n);
        repeat (n) @(negedge iClk);
    endtask

    task automatic press_btn();
        bus.iBtn = 1'b1;
        cycles(12);
        bus.iBtn = 1'b0;
        cycles(12);
    endtask

    int vc0;
    int lat;
    logic [2:0] sa, sb;
    logic [3:0] sr;

    initial begin
        vecs[0] = '{a:3'd5, b:3'd3, cin:1'b0, res:4'b1000};
        vecs[1] = '{a:3'd7, b:3'd7, cin:1'b1, res:4'b1111};
        vecs[2] = '{a:3'd0, b:3'd0, cin:1'b0, res:4'b0000};
        vecs[3] = '{a:3'd1, b:3'd2, cin:1'b1, res:4'b0100};
        vecs[4] = '{a:3'd6, b:3'd1, cin:1'b0, res:4'b0111};
        vecs[5] = '{a:3'd4, b:3'd4, cin:1'b1, res:4'b1001};

        iRst_n     = 1'b0;
        bus.iSw    = 3'd0;
        bus.iSwCin = 1'b0;
        bus.iBtn   = 1'b0;
        cycles(3);
        iRst_n = 1'b1;
        cycles(2);
        check("reset_oA", bus.oA, 0);
        check("reset_oB", bus.oB, 0);
        check("reset_oCin", bus.oCin, 0);
        check("reset_oResult", bus.oResult, 0);
        check("reset_oValid", bus.oValid, 0);
        check("reset_oState", bus.oState, 0);

        for (int i = 0; i < 6; i++) begin
            bus.iSw = vecs[i].a;
            press_btn();
            check("loadA_oA", bus.oA, vecs[i].a);
            check("loadA_state", bus.oState, 1);
            bus.iSw    = vecs[i].b;
            bus.iSwCin = vecs[i].cin;
            vc0 = valid_cnt;
            press_btn();
            check("loadB_oB", bus.oB, vecs[i].b);
            check("loadB_oCin", bus.oCin, vecs[i].cin);
            check("show_oResult", bus.oResult, vecs[i].res);
            check("show_state", bus.oState, 3);
            check("valid_pulses", valid_cnt - vc0, 1);
            check("valid_low_after", bus.oValid, 0);
            press_btn();
            check("clear_oA", bus.oA, 0);
            check("clear_oB", bus.oB, 0);
            check("clear_oCin", bus.oCin, 0);
            check("clear_oResult", bus.oResult, 0);
            check("clear_state", bus.oState, 0);
        end

        // Press latency from a clean raw edge to the state change.
        bus.iSw  = 3'd2;
        bus.iBtn = 1'b1;
        lat = 0;
        while (bus.oState == 2'b00 && lat < 50) begin
            @(negedge iClk);
            lat = lat + 1;
        end
        check("latency_in_range", (lat >= DEB_CNT + 2 && lat <= DEB_CNT + 4) ? 1 : 0, 1);
        cycles(6);
        bus.iBtn = 1'b0;
        cycles(12);
        check("latency_state", bus.oState, 1);

        // Short glitches never get through the debouncer.
        for (int g = 1; g <= 3; g++) begin
            bus.iBtn = 1'b1;
            cycles(g);
            bus.iBtn = 1'b0;
            cycles(15);
            check("glitch_state", bus.oState, 1);
        end

        // A long hold is one press.
        bus.iSw    = 3'd3;
        bus.iSwCin = 1'b1;
        bus.iBtn   = 1'b1;
        cycles(200);
        bus.iBtn = 1'b0;
        cycles(15);
        check("hold_state", bus.oState, 3);
        check("hold_oResult", bus.oResult, 6);
        press_btn();
        check("hold_clear_state", bus.oState, 0);

        // Asynchronous reset mid-operation while in LOAD_B.
        bus.iSw = 3'd6;
        press_btn();
        check("pre_rst_oA", bus.oA, 6);
        check("pre_rst_state", bus.oState, 1);
        #2;
        iRst_n = 1'b0;
        #1;
        check("async_rst_oA", bus.oA, 0);
        check("async_rst_state", bus.oState, 0);
        #9;
        iRst_n = 1'b1;
        cycles(3);
        check("post_rst_state", bus.oState, 0);

        // Switch activity in SHOW has no effect.
        bus.iSw = 3'd2;
        press_btn();
        bus.iSw    = 3'd5;
        bus.iSwCin = 1'b0;
        press_btn();
        check("show2_state", bus.oState, 3);
        check("show2_oResult", bus.oResult, 7);
        sa = bus.oA;
        sb = bus.oB;
        sr = bus.oResult;
        for (int k = 0; k < 20; k++) begin
            bus.iSw    = ~bus.iSw;
            bus.iSwCin = ~bus.iSwCin;
            @(negedge iClk);
            if (bus.oA != sa || bus.oB != sb || bus.oResult != sr || bus.oValid != 1'b0)
                check("show_toggle_stable", 0, 1);
        end
        check("show_toggle_oA", bus.oA, 2);
        check("show_toggle_oB", bus.oB, 5);
        check("show_toggle_oResult", bus.oResult, 7);
        check("valid_only_in_show", valid_wrong_state, 0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
